// File: rtl/welch_pkg.sv
// Shared types and field positions for the Welch-path FFT sequencer.
package welch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } fft_ctrl_state_t;

    localparam int FFT_CFG_FWD_BIT   = 0;
    localparam int FFT_CFG_SCALE_LSB = 1;
    localparam int FFT_CFG_SCALE_W   = 15;

    localparam int ERR_TLAST_UNEXP = 0;
    localparam int ERR_TLAST_MISS  = 1;
    localparam int ERR_DIN_HALT    = 2;
    localparam int ERR_DOUT_HALT   = 3;
    localparam int ERR_W           = 4;

endpackage

// File: rtl/welch_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
// Latency: count visible the cycle after the increment. No backpressure.
module welch_sat_cnt #(
    parameter int W = 16
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/welch_fft_ctrl.sv
// Welch FFT sequencer: config beat, gated sample stream with tlast every NFFT, result-frame count, sticky events.
// Latency: data path is zero-latency combinational; status registered. Backpressure: core tready passed straight to source.
// Optional WELCH_FFT_EVT_CNT_EN adds per-event saturating counters on evt_counts.
module welch_fft_ctrl
    import welch_pkg::*;
#(
    parameter int NFFT    = 1024,
    parameter int FRAME_W = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [FRAME_W-1:0]   n_frames,
    input  logic [15:0]          cfg_word,
    input  logic [63:0]          s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [15:0]          fft_cfg_tdata,
    output logic                 fft_cfg_tvalid,
    input  logic                 fft_cfg_tready,
    output logic [63:0]          fft_din_tdata,
    output logic                 fft_din_tvalid,
    input  logic                 fft_din_tready,
    output logic                 fft_din_tlast,
    input  logic                 fft_dout_tvalid,
    input  logic                 fft_dout_tready,
    input  logic                 fft_dout_tlast,
    input  logic                 evt_tlast_unexpected,
    input  logic                 evt_tlast_missing,
    input  logic                 evt_din_halt,
    input  logic                 evt_dout_halt,
    output logic                 busy,
    output logic                 done,
    output logic [FRAME_W-1:0]   frames_out,
`ifdef WELCH_FFT_EVT_CNT_EN
    output logic [4*FRAME_W-1:0] evt_counts,
`endif
    output logic [ERR_W-1:0]     err_flags
);

    localparam int                SAMP_W    = $clog2(NFFT);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(NFFT - 1);

    fft_ctrl_state_t      state_q, state_d;
    logic [SAMP_W-1:0]    samp_q, samp_d;
    logic [FRAME_W-1:0]   fin_q, fin_d;
    logic [FRAME_W-1:0]   nfr_q, nfr_d;
    logic [15:0]          cfg_q, cfg_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 start_acc;
    logic                 active;
    logic                 in_run;
    logic                 din_hs;
    logic                 dout_fr;
    logic                 drain_hit;
    logic [ERR_W-1:0]     evt_vec;

    always_comb begin
        evt_vec                  = '0;
        evt_vec[ERR_TLAST_UNEXP] = evt_tlast_unexpected;
        evt_vec[ERR_TLAST_MISS]  = evt_tlast_missing;
        evt_vec[ERR_DIN_HALT]    = evt_din_halt;
        evt_vec[ERR_DOUT_HALT]   = evt_dout_halt;
    end

    assign start_acc = (state_q == ST_IDLE) && start;
    assign active    = (state_q != ST_IDLE);
    assign in_run    = (state_q == ST_RUN);
    assign din_hs    = in_run && s_axis_tvalid && fft_din_tready;
    assign dout_fr   = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                       fft_dout_tvalid && fft_dout_tready && fft_dout_tlast;

    // Look ahead one beat so DONE follows the final output tlast by exactly one cycle.
    assign drain_hit = (frames_out == nfr_q) ||
                       (dout_fr && (frames_out == (nfr_q - 1'b1)));

    always_comb begin
        state_d = state_q;
        samp_d  = samp_q;
        fin_d   = fin_q;
        nfr_d   = nfr_q;
        cfg_d   = cfg_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CFG;
                    samp_d  = '0;
                    fin_d   = '0;
                    nfr_d   = (n_frames == '0) ? FRAME_W'(1) : n_frames;
                    cfg_d   = {cfg_word[FFT_CFG_SCALE_LSB +: FFT_CFG_SCALE_W],
                               cfg_word[FFT_CFG_FWD_BIT]};
                    err_d   = '0;
                end
            end
            ST_CFG: begin
                if (fft_cfg_tready) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (din_hs) begin
                    samp_d = samp_q + 1'b1;
                    if (samp_q == SAMP_LAST) begin
                        fin_d = fin_q + 1'b1;
                        if (fin_q == (nfr_q - 1'b1)) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (active) begin
            err_d = err_q | evt_vec;
        end

        // Abort outranks every other transition; status is deliberately left intact.
        if (active && abort) begin
            state_d = ST_IDLE;
            samp_d  = '0;
            fin_d   = '0;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            samp_q  <= '0;
            fin_q   <= '0;
            nfr_q   <= '0;
            cfg_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            samp_q  <= samp_d;
            fin_q   <= fin_d;
            nfr_q   <= nfr_d;
            cfg_q   <= cfg_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    welch_sat_cnt #(.W(FRAME_W)) u_frames_out (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clr     (start_acc),
        .inc     (dout_fr),
        .cnt     (frames_out)
    );

`ifdef WELCH_FFT_EVT_CNT_EN
    for (genvar i = 0; i < ERR_W; i++) begin : g_evt_cnt
        welch_sat_cnt #(.W(FRAME_W)) u_evt_cnt (
            .aclk    (aclk),
            .aresetn (aresetn),
            .clr     (start_acc),
            .inc     (active && evt_vec[i]),
            .cnt     (evt_counts[i*FRAME_W +: FRAME_W])
        );
    end
`endif

    assign s_axis_tready  = in_run && fft_din_tready;
    assign fft_din_tvalid = in_run && s_axis_tvalid;
    assign fft_din_tdata  = s_axis_tdata;
    assign fft_din_tlast  = in_run && (samp_q == SAMP_LAST);
    assign fft_cfg_tvalid = (state_q == ST_CFG);
    assign fft_cfg_tdata  = cfg_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_flags      = err_q;

endmodule

// File: tb/tb_welch_fft_ctrl.sv
// Bench for welch_fft_ctrl with NFFT=16: table of runs, abort sequence, beat scoreboard and a delayed core-output model.
module tb_welch_fft_ctrl;

    localparam int NFFT    = 16;
    localparam int FRAME_W = 16;

    logic                 aclk = 1'b0;
    logic                 aresetn;
    logic                 start, abort;
    logic [FRAME_W-1:0]   n_frames;
    logic [15:0]          cfg_word;
    logic [63:0]          s_axis_tdata;
    logic                 s_axis_tvalid, s_axis_tready;
    logic [15:0]          fft_cfg_tdata;
    logic                 fft_cfg_tvalid, fft_cfg_tready;
    logic [63:0]          fft_din_tdata;
    logic                 fft_din_tvalid, fft_din_tready, fft_din_tlast;
    logic                 fft_dout_tvalid, fft_dout_tready, fft_dout_tlast;
    logic                 evt_tlast_unexpected, evt_tlast_missing, evt_din_halt, evt_dout_halt;
    logic                 busy, done;
    logic [FRAME_W-1:0]   frames_out;
    logic [3:0]           err_flags;
`ifdef WELCH_FFT_EVT_CNT_EN
    logic [4*FRAME_W-1:0] evt_counts;
`endif

    welch_fft_ctrl #(.NFFT(NFFT), .FRAME_W(FRAME_W)) dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .start                (start),
        .abort                (abort),
        .n_frames             (n_frames),
        .cfg_word             (cfg_word),
        .s_axis_tdata         (s_axis_tdata),
        .s_axis_tvalid        (s_axis_tvalid),
        .s_axis_tready        (s_axis_tready),
        .fft_cfg_tdata        (fft_cfg_tdata),
        .fft_cfg_tvalid       (fft_cfg_tvalid),
        .fft_cfg_tready       (fft_cfg_tready),
        .fft_din_tdata        (fft_din_tdata),
        .fft_din_tvalid       (fft_din_tvalid),
        .fft_din_tready       (fft_din_tready),
        .fft_din_tlast        (fft_din_tlast),
        .fft_dout_tvalid      (fft_dout_tvalid),
        .fft_dout_tready      (fft_dout_tready),
        .fft_dout_tlast       (fft_dout_tlast),
        .evt_tlast_unexpected (evt_tlast_unexpected),
        .evt_tlast_missing    (evt_tlast_missing),
        .evt_din_halt         (evt_din_halt),
        .evt_dout_halt        (evt_dout_halt),
        .busy                 (busy),
        .done                 (done),
        .frames_out           (frames_out),
`ifdef WELCH_FFT_EVT_CNT_EN
        .evt_counts           (evt_counts),
`endif
        .err_flags            (err_flags)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [FRAME_W-1:0] nf;
        logic [15:0]        cfg;
        int                 stall;
        bit                 rnd;
        bit                 evt;
        bit                 abt;
        int                 exp_beats;
        logic [FRAME_W-1:0] exp_frames;
        logic [3:0]         exp_err;
    } run_vec_t;

    run_vec_t tbl [6];

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int cyc = 0;
    int mon_beat, mon_idx, cfg_cnt, done_cnt, done_cyc, last_dout_cyc;
    bit cfg_seen, rnd, evt_req, evt_sent, tl_flag;
    logic [15:0] exp_cfg;
    logic [3:0]  err_at_done;
    logic [2:0]  dly;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    function automatic logic [63:0] make_dat(input int i);
        return {16'hA5A5, 16'(i), 32'(i * 7 + 3)};
    endfunction

    always @(posedge aclk) cyc++;

    // Monitor: scoreboard of accepted beats, config beats, output frames and done pulses.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (fft_din_tvalid && fft_din_tready) begin
                chk("din_after_cfg", cfg_seen, 1);
                chk("din_data", fft_din_tdata, make_dat(mon_idx));
                chk("din_tlast", fft_din_tlast, (mon_beat % NFFT) == NFFT - 1);
                if (fft_din_tlast) tl_flag = 1;
                mon_beat++;
                mon_idx++;
            end
            if (fft_cfg_tvalid && fft_cfg_tready) begin
                chk("cfg_data", fft_cfg_tdata, exp_cfg);
                cfg_cnt++;
                cfg_seen = 1;
            end
            if (fft_dout_tvalid && fft_dout_tready && fft_dout_tlast) last_dout_cyc = cyc;
            if (done) begin
                done_cnt++;
                done_cyc    = cyc;
                err_at_done = err_flags;
            end
        end
    end

    // Core output model: each input frame produces an output tlast three cycles later.
    always @(posedge aclk) begin
        #1;
        dly             = {dly[1:0], tl_flag};
        tl_flag         = 0;
        fft_dout_tvalid = dly[2];
        fft_dout_tready = dly[2];
        fft_dout_tlast  = dly[2];
    end

    task automatic run_one(input run_vec_t v);
        int budget;
        int d0;
        @(posedge aclk); #1;
        n_frames = v.nf; cfg_word = v.cfg; exp_cfg = v.cfg;
        start = 1; abort = v.abt;
        fft_cfg_tready = (v.stall == 0);
        s_axis_tvalid = 1; fft_din_tready = 1; s_axis_tdata = make_dat(mon_idx);
        mon_beat = 0; cfg_cnt = 0; cfg_seen = 0;
        rnd = v.rnd; evt_req = v.evt; evt_sent = 0; d0 = done_cnt;
        @(posedge aclk); #1;
        start = 0; abort = 0;
        @(negedge aclk);
        chk("start_busy", busy, 1);
        chk("start_clr_frames", frames_out, 0);
        chk("start_clr_err", err_flags, 0);
        chk("start_cfg_vld", fft_cfg_tvalid, 1);
        for (int i = 0; i < v.stall; i++) begin
            if (i > 0) @(negedge aclk);
            chk("cfg_hold_vld", fft_cfg_tvalid, 1);
            chk("cfg_hold_dat", fft_cfg_tdata, v.cfg);
            chk("din_blocked", {fft_din_tvalid, s_axis_tready}, 2'b00);
        end
        budget = 0;
        while (done_cnt == d0 && budget < 3000) begin
            @(posedge aclk); #1;
            fft_cfg_tready    = 1;
            s_axis_tdata      = make_dat(mon_idx);
            s_axis_tvalid     = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            fft_din_tready    = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            evt_tlast_missing = evt_req && !evt_sent && (mon_beat == 5);
            if (evt_tlast_missing) evt_sent = 1;
            budget++;
        end
        evt_tlast_missing = 0;
        chk("done_seen", done_cnt - d0, 1);
        chk("done_latency", done_cyc, last_dout_cyc + 1);
        chk("beats", mon_beat, v.exp_beats);
        chk("err_at_done", err_at_done, v.exp_err);
        chk("cfg_beats", cfg_cnt, 1);
        @(negedge aclk);
        chk("done_one_cycle", {done, busy}, 2'b00);
        chk("frames_out", frames_out, v.exp_frames);
        chk("err_flags", err_flags, v.exp_err);
`ifdef WELCH_FFT_EVT_CNT_EN
        chk("evt_cnt_miss", evt_counts[FRAME_W +: FRAME_W], FRAME_W'(v.evt));
`endif
    endtask

    initial begin
        //          nf  cfg       stall rnd evt abt beats frames err
        tbl[0] = '{3, 16'h0AAB, 0, 0, 0, 0, 48, 3, 4'b0000};
        tbl[1] = '{3, 16'h1234, 5, 0, 0, 0, 48, 3, 4'b0000};
        tbl[2] = '{2, 16'h7FFE, 2, 1, 0, 0, 32, 2, 4'b0000};
        tbl[3] = '{1, 16'h0001, 0, 0, 1, 0, 16, 1, 4'b0010};
        tbl[4] = '{0, 16'h0055, 1, 1, 0, 0, 16, 1, 4'b0000};
        tbl[5] = '{1, 16'h0AAB, 0, 0, 0, 1, 16, 1, 4'b0000};

        aresetn = 0; start = 0; abort = 0; n_frames = 0; cfg_word = 0;
        s_axis_tdata = 0; s_axis_tvalid = 0; fft_cfg_tready = 0; fft_din_tready = 0;
        fft_dout_tvalid = 0; fft_dout_tready = 0; fft_dout_tlast = 0;
        evt_tlast_unexpected = 0; evt_tlast_missing = 0; evt_din_halt = 0; evt_dout_halt = 0;
        mon_beat = 0; mon_idx = 0; cfg_cnt = 0; done_cnt = 0; done_cyc = 0; last_dout_cyc = 0;
        cfg_seen = 0; rnd = 0; evt_req = 0; evt_sent = 0; tl_flag = 0; dly = 0;
        exp_cfg = 0; err_at_done = 0;

        repeat (3) @(negedge aclk);
        aresetn = 1;
        s_axis_tvalid = 1; fft_din_tready = 1; fft_cfg_tready = 1;
        @(negedge aclk);
        chk("rst_status", {busy, done, err_flags}, 6'b0);
        chk("rst_frames", frames_out, 0);
        chk("rst_cfg", {fft_cfg_tvalid, fft_cfg_tdata}, 17'b0);
        chk("rst_din", {fft_din_tvalid, s_axis_tready, fft_din_tlast}, 3'b0);

        for (int r = 0; r < 5; r++) run_one(tbl[r]);

        // Abort in frame 2 at sample 7, with a simultaneous start that must lose.
        begin
            int d0;
            int b;
            @(posedge aclk); #1;
            n_frames = 3; cfg_word = 16'h0AAB; exp_cfg = 16'h0AAB; start = 1;
            fft_cfg_tready = 1; s_axis_tvalid = 1; fft_din_tready = 1;
            s_axis_tdata = make_dat(mon_idx);
            mon_beat = 0; cfg_cnt = 0; cfg_seen = 0; d0 = done_cnt;
            @(posedge aclk); #1;
            start = 0;
            b = 0;
            while (mon_beat < 23 && b < 200) begin
                @(posedge aclk); #1;
                s_axis_tdata = make_dat(mon_idx);
                b++;
            end
            chk("abort_reach", mon_beat, 23);
            abort = 1; start = 1;
            @(posedge aclk); #1;
            abort = 0; start = 0;
            @(negedge aclk);
            chk("abort_idle", {busy, fft_cfg_tvalid, fft_din_tvalid, s_axis_tready}, 4'b0);
            chk("abort_beats", mon_beat, 24);
            chk("abort_frames_hold", frames_out, 1);
            chk("abort_err_hold", err_flags, 0);
            repeat (10) @(negedge aclk);
            chk("abort_no_done", done_cnt, d0);
            chk("abort_still_idle", busy, 0);
        end

        run_one(tbl[5]);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/welch_fft_ctrl.md
# welch_fft_ctrl

Sequencer for the Welch-path FFT core. Per run it:
- loads the core's configuration word over its config AXI-Stream channel;
- gates the sample stream into the core and generates `tlast` every `NFFT` samples for the requested number of frames;
- counts result frames leaving the core and reports completion;
- latches the core's event outputs as status.

It sits between the windowing stage and the FFT core, under control of the Welch register block.

## Interface
- `NFFT`, 1024: transform length in samples; power of two, 8..65536.
- `FRAME_W`, 16: width of the frame-count request and counters.
- `aclk` in 1: sole clock.
- `aresetn` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle run request; ignored unless state is IDLE.
- `abort` in 1: one-cycle cancel; honoured in any state except IDLE.
- `n_frames` in `FRAME_W`: frames per run, sampled at accepted `start`; 0 is treated as 1.
- `cfg_word` in 16: `{scale_sch[14:0], fwd_inv}`, sampled at accepted `start`.
- `s_axis_tdata` / `tvalid` / `tready`: in 64 / in 1 / out 1; windowed samples, no `tlast`.
- `fft_cfg_tdata` / `tvalid` / `tready`: out 16 / out 1 / in 1; config channel of the core.
- `fft_din_tdata` / `tvalid` / `tready` / `tlast`: out 64 / out 1 / in 1 / out 1; data-in channel of the core.
- `fft_dout_tvalid`, `fft_dout_tready`, `fft_dout_tlast` in 1 each: monitor taps of the core output handshake.
- `evt_tlast_unexpected`, `evt_tlast_missing`, `evt_din_halt`, `evt_dout_halt` in 1 each: core event pulses.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse at run completion.
- `frames_out` out `FRAME_W`: result frames observed in the current or last run.
- `err_flags` out 4: sticky `{dout_halt, din_halt, tlast_missing, tlast_unexpected}`.

## Operation
- States and transitions:
  - IDLE: `start` → CFG.
  - CFG: `fft_cfg_tvalid`=1 with the latched `cfg_word`; handshake → RUN.
  - RUN: data passes through; the `tlast` beat of frame `n_frames` → DRAIN.
  - DRAIN: waits for `frames_out == n_frames` → DONE.
  - DONE: one cycle, `done`=1 → IDLE.
- Data pass-through in RUN:
  - `fft_din_tvalid = s_axis_tvalid`.
  - `s_axis_tready = fft_din_tready`.
  - `tdata` is passed combinationally.
  - Outside RUN, both valid and ready are 0.
- Sample counter: 0..`NFFT`-1 increments on each din handshake. `fft_din_tlast` = 1 when counter = `NFFT`-1. The counter wraps to 0 and the input frame counter increments.
- Output frame counter (`frames_out`):
  - increments on `fft_dout_tvalid & fft_dout_tready & fft_dout_tlast` in RUN or DRAIN;
  - cleared when `start` is accepted;
  - saturates at all-ones.
- `err_flags`: each bit is set by its event pulse in any non-IDLE state and cleared on accepted `start`. A set and a clear in the same cycle leave the bit cleared.
- `abort`:
  - forces IDLE on the next edge and clears the sample counter;
  - no `done` is issued;
  - `frames_out` and `err_flags` hold their values.
  - A partially sent frame is left to the core's own `tlast_missing` handling.
- `start` and `abort` in the same cycle while in IDLE: `start` wins. In any other state, `abort` wins.

## Timing
- Reset values: state IDLE; all counters 0; `busy`=0, `done`=0, `err_flags`=0; `fft_cfg_tvalid`=0, `fft_cfg_tdata`=0; `fft_din_tvalid`=0.
- Cycle latencies:
  - `start` at edge k: CFG and `fft_cfg_tvalid`=1 from cycle k+1.
  - Config handshake at edge m: RUN from m+1, so the first sample is accepted no earlier than m+1.
  - Last `tlast` beat at edge t: DRAIN from t+1.
  - Final output `tlast` at edge d: DONE (`done`=1) in cycle d+1, IDLE at d+2.
  - If the final output frame completes on or before t, DONE is entered at t+2 after a single DRAIN cycle.
- The data path adds zero latency and is combinational valid/ready/data. `fft_din_tlast` decodes from a register.
- `fft_cfg_tvalid` is held until `tready`; `fft_cfg_tdata` is stable while valid.
- All status outputs are registered.

## Configuration
- `WELCH_FFT_EVT_CNT_EN` defined:
  - adds four `FRAME_W` saturating event counters, cleared on accepted `start`;
  - exposes them on output `evt_counts` (4×`FRAME_W`, packed in `err_flags` bit order).
- Not defined: the port is absent and only the sticky flags exist.

## Structure
- Package `welch_pkg` holds:
  - the state enum `fft_ctrl_state_t`;
  - the config-word field positions (`FFT_CFG_FWD_BIT`=0, `FFT_CFG_SCALE_LSB`=1);
  - the `err_flags` bit indices.
- Sub-module `welch_sat_cnt`: parameterised saturating counter with clear and increment inputs. It is reused for `frames_out` and the optional event counters.

## Test plan
- `NFFT`=16, `n_frames`=3, `cfg_word`=16'h0AAB, core ready always:
  - one config beat 16'h0AAB;
  - 48 din beats with `tlast` at beats 15, 31, 47;
  - `done` one cycle after the 3rd output `tlast`;
  - `frames_out`=3.
- Config `tready` held low 5 cycles: `fft_cfg_tvalid` stays high with stable data, and no din beat occurs before the handshake.
- Random `fft_din_tready` / `s_axis_tvalid` stalls: `tlast` is still on every 16th accepted beat, and no beat is duplicated or lost (scoreboard check).
- `abort` mid-frame 2 at sample 7: IDLE next cycle, `done` never asserted, a new `start` runs normally from sample 0.
- `evt_tlast_missing` pulse during RUN: `err_flags`=4'b0010, held through DONE, cleared by the next `start`. With the macro defined, the corresponding `evt_counts` field reads 1.
- `n_frames`=0: behaves as 1, giving 16 din beats and `done` after one output frame.
